// File: rtl/fpu_seq_ctrl.sv
// Multi-cycle FPU sequencer: stalls decode for the selected unit latency, then strobes writeback.
// Optional stall-cycle counter port enabled with `define FPU_STALL_CNT_EN.
module fpu_seq_ctrl #(
    parameter int unsigned LAT_SHORT = 2,
    parameter int unsigned LAT_MUL   = 2,
    parameter int unsigned LAT_DIV   = 9,
    parameter int unsigned LAT_SQRT  = 9,
    parameter int unsigned RD_W      = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            fpu_stall_op,
    input  logic [1:0]      fpu_class,
    input  logic [RD_W-1:0] rd,
    input  logic            flush,
    output logic            stall,
    output logic            fpu_start,
    output logic            busy,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd
`ifdef FPU_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam bit LAT_OK = (LAT_SHORT >= 1) && (LAT_SHORT <= 63) &&
                            (LAT_MUL   >= 1) && (LAT_MUL   <= 63) &&
                            (LAT_DIV   >= 1) && (LAT_DIV   <= 63) &&
                            (LAT_SQRT  >= 1) && (LAT_SQRT  <= 63);

    if (!LAT_OK) begin : g_lat_range
        $error("fpu_seq_ctrl: every latency parameter must be in 1..63");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic [5:0]      cnt, cnt_nx, lat_sel;
    logic [RD_W-1:0] rd_q;
    logic            accept;

    always_comb begin
        lat_sel = 6'(LAT_SHORT);
        case (fpu_class)
            2'b00:   lat_sel = 6'(LAT_SHORT);
            2'b01:   lat_sel = 6'(LAT_MUL);
            2'b10:   lat_sel = 6'(LAT_DIV);
            default: lat_sel = 6'(LAT_SQRT);
        endcase
    end

    // A new op may start from IDLE or from the DONE cycle of the previous one.
    always_comb begin
        accept    = issue_valid & fpu_stall_op & ~flush & ((state == IDLE) | (state == DONE));
        state_nx  = state;
        cnt_nx    = cnt;
        fpu_start = accept;
        stall     = accept | (state == BUSY);
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    cnt_nx   = lat_sel - 6'd1;
                    state_nx = (lat_sel == 6'd1) ? DONE : BUSY;
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 6'd1;
                    if (cnt == 6'd1) state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_q     <= '0;
            busy     <= 1'b0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            busy     <= (state_nx == BUSY);
            wb_valid <= (state_nx == DONE);
            if (accept) rd_q <= rd;
            // A single-cycle op goes straight to DONE, so take rd directly.
            if (state_nx == DONE) wb_rd <= accept ? rd : rd_q;
        end
    end

`ifdef FPU_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed bench for fpu_seq_ctrl with a writeback scoreboard; second instance runs LAT_SHORT=1.
module tb_fpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic       fpu_stall_op = 1'b0;
    logic [1:0] fpu_class = 2'b00;
    logic [4:0] rd = 5'd0;
    logic       flush = 1'b0;

    logic       stall, fpu_start, busy, wb_valid;
    logic [4:0] wb_rd;
    logic       stall1, fpu_start1, busy1, wb_valid1;
    logic [4:0] wb_rd1;
`ifdef FPU_STALL_CNT_EN
    logic [31:0] stall_cycles, stall_cycles1;
`endif

    typedef struct {
        int         due;
        logic [4:0] rd;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    fpu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .fpu_stall_op(fpu_stall_op),
        .fpu_class(fpu_class), .rd(rd), .flush(flush), .stall(stall), .fpu_start(fpu_start),
        .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd)
`ifdef FPU_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    fpu_seq_ctrl #(.LAT_SHORT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .fpu_stall_op(fpu_stall_op),
        .fpu_class(fpu_class), .rd(rd), .flush(flush), .stall(stall1), .fpu_start(fpu_start1),
        .busy(busy1), .wb_valid(wb_valid1), .wb_rd(wb_rd1)
`ifdef FPU_STALL_CNT_EN
        , .stall_cycles(stall_cycles1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic iv, input logic sop, input logic [1:0] cls,
                                  input logic [4:0] r, input logic fl);
        @(posedge clk);
        #1;
        issue_valid  = iv;
        fpu_stall_op = sop;
        fpu_class    = cls;
        rd           = r;
        flush        = fl;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
    endtask

    task automatic push_exp(input int lat, input logic [4:0] r);
        exp_t e;
        e.due = cyc + lat;
        e.rd  = r;
        sb.push_back(e);
    endtask

    // Writeback scoreboard: every expected strobe must land on its due cycle, nothing else.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check_output("wb_valid", 32'(wb_valid), 32'd1);
                check_output("wb_rd", 32'(wb_rd), 32'(e.rd));
            end else begin
                check_output("wb_quiet", 32'(wb_valid), 32'd0);
            end
        end
    end

    initial begin
        #22 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_output("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_output("rst_stall", 32'(stall), 32'd0);
`ifdef FPU_STALL_CNT_EN
        check_output("rst_stall_cycles", stall_cycles, 32'd0);
`endif

        // integer op passes through
        apply_stimulus(1'b1, 1'b0, 2'b10, 5'd3, 1'b0);
        @(negedge clk);
        check_output("int_stall", 32'(stall), 32'd0);
        check_output("int_start", 32'(fpu_start), 32'd0);
        idle();
        @(negedge clk);
        check_output("int_busy", 32'(busy), 32'd0);

        // fdiv rd=7: stall 9 cycles, writeback on the 9th cycle after issue
        apply_stimulus(1'b1, 1'b1, 2'b10, 5'd7, 1'b0);
        push_exp(9, 5'd7);
        @(negedge clk);
        check_output("div_stall0", 32'(stall), 32'd1);
        check_output("div_start0", 32'(fpu_start), 32'd1);
        check_output("div_busy0", 32'(busy), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) apply_stimulus(1'b1, 1'b1, 2'b00, 5'd1, 1'b0);
            else idle();
            @(negedge clk);
            check_output("div_stall", 32'(stall), 32'd1);
            check_output("div_start", 32'(fpu_start), 32'd0);
            check_output("div_busy", 32'(busy), 32'd1);
        end
        idle();
        @(negedge clk);
        check_output("div_stall_end", 32'(stall), 32'd0);
        check_output("div_busy_end", 32'(busy), 32'd0);
        idle();

        // fadd: latency 1 on dut1, latency 2 on dut
        apply_stimulus(1'b1, 1'b1, 2'b00, 5'd3, 1'b0);
        push_exp(2, 5'd3);
        @(negedge clk);
        check_output("l1_stall0", 32'(stall1), 32'd1);
        check_output("l1_start0", 32'(fpu_start1), 32'd1);
        check_output("l1_busy0", 32'(busy1), 32'd0);
        idle();
        @(negedge clk);
        check_output("l1_stall1", 32'(stall1), 32'd0);
        check_output("l1_busy1", 32'(busy1), 32'd0);
        check_output("l1_wb_valid", 32'(wb_valid1), 32'd1);
        check_output("l1_wb_rd", 32'(wb_rd1), 32'd3);
        check_output("l2_stall1", 32'(stall), 32'd1);
        idle();
        @(negedge clk);
        check_output("l1_wb_done", 32'(wb_valid1), 32'd0);
        idle();

        // fmul rd=4 then fsqrt rd=5 accepted in the DONE cycle
        apply_stimulus(1'b1, 1'b1, 2'b01, 5'd4, 1'b0);
        push_exp(2, 5'd4);
        @(negedge clk);
        check_output("mul_start", 32'(fpu_start), 32'd1);
        idle();
        @(negedge clk);
        check_output("mul_stall1", 32'(stall), 32'd1);
        check_output("mul_start1", 32'(fpu_start), 32'd0);
        apply_stimulus(1'b1, 1'b1, 2'b11, 5'd5, 1'b0);
        push_exp(9, 5'd5);
        @(negedge clk);
        check_output("b2b_start", 32'(fpu_start), 32'd1);
        check_output("b2b_stall", 32'(stall), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            idle();
            @(negedge clk);
            check_output("sqrt_stall", 32'(stall), 32'd1);
            check_output("sqrt_busy", 32'(busy), 32'd1);
        end
        idle();
        @(negedge clk);
        check_output("sqrt_stall_end", 32'(stall), 32'd0);
        idle();

        // flush three cycles after an fdiv issue cancels it
        apply_stimulus(1'b1, 1'b1, 2'b10, 5'd9, 1'b0);
        @(negedge clk);
        check_output("fl_start", 32'(fpu_start), 32'd1);
        idle();
        idle();
        apply_stimulus(1'b0, 1'b0, 2'b00, 5'd0, 1'b1);
        @(negedge clk);
        check_output("fl_stall_busy", 32'(stall), 32'd1);
        idle();
        @(negedge clk);
        check_output("fl_stall_after", 32'(stall), 32'd0);
        check_output("fl_busy_after", 32'(busy), 32'd0);
        repeat (7) idle();
        apply_stimulus(1'b1, 1'b1, 2'b01, 5'd13, 1'b1);
        @(negedge clk);
        check_output("fl_idle_block_start", 32'(fpu_start), 32'd0);
        check_output("fl_idle_block_stall", 32'(stall), 32'd0);
        apply_stimulus(1'b1, 1'b1, 2'b01, 5'd12, 1'b0);
        push_exp(2, 5'd12);
        @(negedge clk);
        check_output("fl_reissue_start", 32'(fpu_start), 32'd1);
        repeat (3) idle();

        // flush during DONE keeps the writeback but blocks a new accept
        apply_stimulus(1'b1, 1'b1, 2'b01, 5'd6, 1'b0);
        push_exp(2, 5'd6);
        idle();
        apply_stimulus(1'b1, 1'b1, 2'b10, 5'd8, 1'b1);
        @(negedge clk);
        check_output("fl_done_start", 32'(fpu_start), 32'd0);
        check_output("fl_done_stall", 32'(stall), 32'd0);
        idle();
        @(negedge clk);
        check_output("fl_done_busy", 32'(busy), 32'd0);
        check_output("fl_done_stall2", 32'(stall), 32'd0);

        // asynchronous reset mid-BUSY abandons the op
        apply_stimulus(1'b1, 1'b1, 2'b10, 5'd11, 1'b0);
        repeat (3) idle();
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_stall", 32'(stall), 32'd0);
        check_output("arst_wb_valid", 32'(wb_valid), 32'd0);
`ifdef FPU_STALL_CNT_EN
        check_output("arst_stall_cycles", stall_cycles, 32'd0);
`endif
        #3 rst_n = 1'b1;
        repeat (12) idle();

        // two fdivs and one fmul with integer ops interleaved: 9+9+2 stall cycles
        apply_stimulus(1'b1, 1'b1, 2'b10, 5'd20, 1'b0);
        push_exp(9, 5'd20);
        repeat (9) apply_stimulus(1'b1, 1'b0, 2'b01, 5'd2, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'b10, 5'd21, 1'b0);
        push_exp(9, 5'd21);
        repeat (9) apply_stimulus(1'b1, 1'b0, 2'b11, 5'd2, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'b01, 5'd22, 1'b0);
        push_exp(2, 5'd22);
        repeat (2) apply_stimulus(1'b1, 1'b0, 2'b00, 5'd2, 1'b0);
        repeat (3) idle();
`ifdef FPU_STALL_CNT_EN
        @(negedge clk);
        check_output("stall_cycles_total", stall_cycles, 32'd20);
`endif

        for (int i = 0; i < 30 && sb.size() > 0; i++) idle();
        @(negedge clk);
        check_output("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
